race_controller: RTL and testbench
==================================

Name: race_controller

Overview:
Top-level race sequencer for the kart game datapath. Derives a once-per-frame update tick from the VGA raster counters and runs the race phase FSM (idle, countdown, race, win/lose). Counts laps from ordered checkpoint hits and follows the opponent's game status received over the link. Drives game_stat and gates the per-frame position/direction update in the game module.

Parameters:
TICK_H, 1198, hcount value at which the frame tick fires (blanking interval)
TICK_V, 800, vcount value at which the frame tick fires
COUNT_START, 3, countdown start value (1..3)
COUNT_FRAMES, 60, frame ticks per countdown step (2..63)
LAPS, 3, laps needed to win (1..3)
CP_NUM, 4, checkpoints per lap, ids 0..CP_NUM-1 (2..4)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
btnu  in  1  start/restart button, already debounced, level
hcount  in  11  raster horizontal count
vcount  in  10  raster vertical count
cp_hit  in  1  one-cycle pulse: player kart entered a checkpoint
cp_id  in  2  checkpoint index, valid with cp_hit
r_opp_game  in  3  opponent game_stat received over the link
r_opp_rst  in  1  opponent requested restart, level
frame_tick  out  1  one-cycle pulse per frame
update_en  out  1  one-cycle pulse: game module advances physics this cycle
game_stat  out  3  0 IDLE, 1 COUNTDOWN, 2 RACE, 3 WIN, 4 LOSE
countdown  out  2  current countdown digit shown on screen
lap  out  2  completed laps
player_rst  out  1  one-cycle pulse: reload kart start positions

Behaviour:
- Reset (rst=0, async): state IDLE; game_stat=0, countdown=0, lap=0, frame_tick=0, update_en=0, player_rst=0. All internal counters and edge-detect flops clear. Reset mid-race aborts immediately.
- Frame tick: match = (hcount==TICK_H && vcount==TICK_V). frame_tick is registered and pulses for 1 cycle, 1 cycle after the rising edge of match. A match held for several cycles still gives a single pulse.
- btnu edge: registered btnu_q. start = btnu & ~btnu_q.
- IDLE -> COUNTDOWN: on start, or when r_opp_game==1. On entry: countdown=COUNT_START, frame counter=0, lap=0, expected checkpoint=1, player_rst pulses 1 cycle.
- COUNTDOWN:
  - Each frame_tick increments the frame counter.
  - At frame_tick with counter==COUNT_FRAMES-1: counter=0 and countdown decrements.
  - If countdown==1 at that tick: go to RACE with countdown=0.
  - Total COUNTDOWN length is exactly COUNT_START*COUNT_FRAMES ticks.
- RACE:
  - update_en = frame_tick registered alongside it, so both pulse in the same cycle. update_en=0 in every other state.
  - cp_hit with cp_id==expected: expected=(expected+1) mod CP_NUM. If cp_id==0, lap increments.
  - cp_hit with any other id is ignored, so skipping or reversing never counts.
  - When lap reaches LAPS: go to WIN in the same cycle lap updates.
  - r_opp_game==3 while in RACE: go to LOSE.
  - Simultaneous own finish and opponent WIN: WIN has priority.
- WIN / LOSE: game_stat and lap hold. start -> IDLE, with lap=0 and countdown=0.
- r_opp_rst=1 in any state: synchronous return to IDLE next cycle, player_rst pulses 1 cycle, counters clear. This has priority over all other transitions.
- game_stat is a registered copy of the state encoding, never X. Encodings 5..7 are unused; an illegal state recovers to IDLE.
- cp_hit outside RACE is ignored. Ticks during IDLE/WIN/LOSE only drive frame_tick.
- Widths: frame counter is 6 bits; lap and expected are 2 bits. No wrap is possible within the parameter limits.

Test Plan:
- Reset then tick: rst low 2 cycles, vcount=800, sweep hcount 1198..1200 for 10 frames -> all outputs 0 during reset; afterwards frame_tick gives exactly 10 single-cycle pulses, update_en stays 0, game_stat=0.
- Countdown (COUNT_FRAMES=2): btnu pulse -> player_rst 1 cycle, game_stat=1, countdown 3->2->1 every 2 ticks; after tick 6 game_stat=2, countdown=0; update_en then pulses with each tick.
- Laps (LAPS=1, CP_NUM=4): in RACE send cp_id 1,3,2,3,0 -> id 3 first ignored; after the final 0, lap=1 and game_stat=3 in the same cycle.
- Opponent wins: in RACE set r_opp_game=3 -> game_stat=4 next cycle. Same cycle as own final checkpoint -> game_stat=3.
- Remote start/restart: in IDLE r_opp_game=1 -> COUNTDOWN with player_rst pulse. In RACE r_opp_rst=1 -> game_stat=0, lap=0, player_rst 1 cycle.
- Async reset mid-COUNTDOWN: drop rst between clock edges -> outputs clear immediately without waiting for a clock edge; after release, the FSM resumes from IDLE.

Source files
------------

// File: rtl/race_controller.sv
// rtl/race_controller.sv - race phase sequencer: frame tick, countdown, laps, win/lose
module race_controller #(
    parameter int TICK_H       = 1198,
    parameter int TICK_V       = 800,
    parameter int COUNT_START  = 3,
    parameter int COUNT_FRAMES = 60,
    parameter int LAPS         = 3,
    parameter int CP_NUM       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btnu,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        cp_hit,
    input  logic [1:0]  cp_id,
    input  logic [2:0]  r_opp_game,
    input  logic        r_opp_rst,
    output logic        frame_tick,
    output logic        update_en,
    output logic [2:0]  game_stat,
    output logic [1:0]  countdown,
    output logic [1:0]  lap,
    output logic        player_rst
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_RACE  = 3'd2,
        S_WIN   = 3'd3,
        S_LOSE  = 3'd4
    } state_t;

    localparam logic [5:0] FRAME_LAST = 6'(COUNT_FRAMES - 1);
    localparam logic [1:0] CD_INIT    = 2'(COUNT_START);
    localparam logic [1:0] LAP_FINAL  = 2'(LAPS - 1);
    localparam logic [1:0] CP_LAST    = 2'(CP_NUM - 1);

    state_t     state;
    logic       match;
    logic       match_q;
    logic       tick_rise;
    logic       btnu_q;
    logic       start;
    logic       opp_rst_q;
    logic       cp_ok;
    logic       finish;
    logic [5:0] frame_cnt;
    logic [1:0] expected;

    assign match     = (hcount == 11'(TICK_H)) && (vcount == 10'(TICK_V));
    assign tick_rise = match & ~match_q;
    assign start     = btnu & ~btnu_q;
    assign cp_ok     = cp_hit && (cp_id == expected);
    assign finish    = cp_ok && (cp_id == 2'd0) && (lap == LAP_FINAL);
    assign game_stat = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_q    <= 1'b0;
            frame_tick <= 1'b0;
            btnu_q     <= 1'b0;
            opp_rst_q  <= 1'b0;
        end else begin
            match_q    <= match;
            frame_tick <= tick_rise;
            btnu_q     <= btnu;
            opp_rst_q  <= r_opp_rst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            countdown  <= 2'd0;
            lap        <= 2'd0;
            frame_cnt  <= 6'd0;
            expected   <= 2'd0;
            update_en  <= 1'b0;
            player_rst <= 1'b0;
        end else begin
            update_en  <= 1'b0;
            player_rst <= 1'b0;
            // Remote restart overrides every phase; the reload pulse fires once per request.
            if (r_opp_rst) begin
                state      <= S_IDLE;
                player_rst <= ~opp_rst_q;
                countdown  <= 2'd0;
                lap        <= 2'd0;
                frame_cnt  <= 6'd0;
                expected   <= 2'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start || r_opp_game == 3'd1) begin
                            state      <= S_COUNT;
                            countdown  <= CD_INIT;
                            frame_cnt  <= 6'd0;
                            lap        <= 2'd0;
                            expected   <= 2'd1;
                            player_rst <= 1'b1;
                        end
                    end
                    S_COUNT: begin
                        if (frame_tick) begin
                            if (frame_cnt == FRAME_LAST) begin
                                frame_cnt <= 6'd0;
                                if (countdown == 2'd1) begin
                                    state     <= S_RACE;
                                    countdown <= 2'd0;
                                end else begin
                                    countdown <= countdown - 2'd1;
                                end
                            end else begin
                                frame_cnt <= frame_cnt + 6'd1;
                            end
                        end
                    end
                    S_RACE: begin
                        update_en <= tick_rise;
                        if (cp_ok) begin
                            expected <= (expected == CP_LAST) ? 2'd0 : expected + 2'd1;
                            if (cp_id == 2'd0)
                                lap <= lap + 2'd1;
                        end
                        // Own finish wins a tie against the opponent's finish.
                        if (finish) begin
                            state     <= S_WIN;
                            update_en <= 1'b0;
                        end else if (r_opp_game == 3'd3) begin
                            state     <= S_LOSE;
                            update_en <= 1'b0;
                        end
                    end
                    S_WIN, S_LOSE: begin
                        if (start) begin
                            state     <= S_IDLE;
                            lap       <= 2'd0;
                            countdown <= 2'd0;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        countdown <= 2'd0;
                        lap       <= 2'd0;
                        frame_cnt <= 6'd0;
                        expected  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_race_controller.sv
// tb/tb_race_controller.sv - self-checking bench for race_controller
module tb_race_controller;

    localparam int CS  = 3;
    localparam int CF  = 2;
    localparam int NL  = 1;
    localparam int NCP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btnu = 1'b0;
    logic [10:0] hcount = 11'd0;
    logic [9:0]  vcount = 10'd800;
    logic        cp_hit = 1'b0;
    logic [1:0]  cp_id = 2'd0;
    logic [2:0]  r_opp_game = 3'd0;
    logic        r_opp_rst = 1'b0;
    logic        frame_tick;
    logic        update_en;
    logic [2:0]  game_stat;
    logic [1:0]  countdown;
    logic [1:0]  lap;
    logic        player_rst;

    race_controller #(
        .TICK_H(1198), .TICK_V(800), .COUNT_START(CS),
        .COUNT_FRAMES(CF), .LAPS(NL), .CP_NUM(NCP)
    ) dut (
        .clk(clk), .rst(rst), .btnu(btnu), .hcount(hcount), .vcount(vcount),
        .cp_hit(cp_hit), .cp_id(cp_id), .r_opp_game(r_opp_game), .r_opp_rst(r_opp_rst),
        .frame_tick(frame_tick), .update_en(update_en), .game_stat(game_stat),
        .countdown(countdown), .lap(lap), .player_rst(player_rst)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rpos = 0;

    // Reference: phase plus ticks elapsed since countdown began; digit derived arithmetically.
    int m_phase, m_ticks, m_laps, m_next;
    bit m_ft, m_upd, m_prst, mm_prev, mb_prev, mo_prev;

    wire [9:0] dut_vec = {frame_tick, update_en, game_stat, countdown, lap, player_rst};

    function automatic logic [9:0] exp_vec();
        int cd;
        cd = (m_phase == 1) ? CS - m_ticks / CF : 0;
        return {m_ft, m_upd, 3'(m_phase), 2'(cd), 2'(m_laps), m_prst};
    endfunction

    task automatic model_reset();
        m_phase = 0; m_ticks = 0; m_laps = 0; m_next = 0;
        m_ft = 0; m_upd = 0; m_prst = 0; mm_prev = 0; mb_prev = 0; mo_prev = 0;
    endtask

    task automatic model_update();
        bit match, start, ft_pre, fin;
        int ph;
        match  = (hcount == 11'd1198) && (vcount == 10'd800);
        start  = btnu && !mb_prev;
        ft_pre = m_ft;
        ph     = m_phase;
        fin    = 0;
        m_prst = 0;
        if (r_opp_rst) begin
            m_prst = !mo_prev;
            m_phase = 0; m_laps = 0; m_ticks = 0;
        end else begin
            case (ph)
                0: if (start || r_opp_game == 3'd1) begin
                    m_phase = 1; m_ticks = 0; m_laps = 0; m_next = 1; m_prst = 1;
                end
                1: if (ft_pre) begin
                    m_ticks++;
                    if (m_ticks == CS * CF) m_phase = 2;
                end
                2: begin
                    if (cp_hit && cp_id == m_next) begin
                        m_next = (m_next + 1) % NCP;
                        if (cp_id == 2'd0) begin
                            m_laps++;
                            if (m_laps == NL) begin m_phase = 3; fin = 1; end
                        end
                    end
                    if (!fin && r_opp_game == 3'd3) m_phase = 4;
                end
                default: if (start) begin m_phase = 0; m_laps = 0; end
            endcase
        end
        m_ft  = match && !mm_prev;
        m_upd = match && !mm_prev && ph == 2 && m_phase == 2;
        mm_prev = match; mb_prev = btnu; mo_prev = r_opp_rst;
    endtask

    task automatic step();
        case (rpos % 8)
            0, 1:    hcount = 11'd1198;
            2:       hcount = 11'd1199;
            3:       hcount = 11'd1200;
            default: hcount = 11'($urandom_range(0, 1197));
        endcase
        vcount = 10'd800;
        @(posedge clk);
        if (rst) model_update();
        @(negedge clk);
        rpos++;
    endtask

    task automatic go_race();
        int n;
        if (game_stat == 3'd3 || game_stat == 3'd4) begin
            btnu = 1; step(); btnu = 0; step();
        end
        btnu = 1; step(); btnu = 0;
        n = 0;
        while (game_stat != 3'd2 && n < 200) begin
            step(); n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL go_race_vec: got %h expected %h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (game_stat !== 3'd2) begin
            errors++; $display("FAIL go_race_timeout: game_stat %0d expected 2", game_stat);
        end
    endtask

    task automatic test_reset();
        int n_ft, n_up, bad;
        rst = 0; model_reset();
        step(); step();
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rst_frame_tick: got %b expected 0", frame_tick); end
        checks++; if (update_en !== 1'b0) begin errors++; $display("FAIL rst_update_en: got %b expected 0", update_en); end
        checks++; if (game_stat !== 3'd0) begin errors++; $display("FAIL rst_game_stat: got %0d expected 0", game_stat); end
        checks++; if (countdown !== 2'd0) begin errors++; $display("FAIL rst_countdown: got %0d expected 0", countdown); end
        checks++; if (lap !== 2'd0) begin errors++; $display("FAIL rst_lap: got %0d expected 0", lap); end
        checks++; if (player_rst !== 1'b0) begin errors++; $display("FAIL rst_player_rst: got %b expected 0", player_rst); end
        rst = 1; rpos = 0;
        n_ft = 0; n_up = 0; bad = 0;
        repeat (80) begin
            step();
            n_ft += int'(frame_tick);
            n_up += int'(update_en);
            if (dut_vec !== exp_vec()) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL tick_vec: %0d cycles differ, required 0", bad); end
        checks++; if (n_ft != 10) begin errors++; $display("FAIL tick_count: got %0d pulses expected 10", n_ft); end
        checks++; if (n_up != 0) begin errors++; $display("FAIL tick_update_en: got %0d pulses expected 0", n_up); end
        checks++; if (game_stat !== 3'd0) begin errors++; $display("FAIL tick_game_stat: got %0d expected 0", game_stat); end
    endtask

    task automatic test_countdown();
        int nt, n, n_ft, n_up;
        btnu = 1; step(); btnu = 0;
        checks++; if (player_rst !== 1'b1) begin errors++; $display("FAIL cd_player_rst: got %b expected 1", player_rst); end
        checks++; if (game_stat !== 3'd1) begin errors++; $display("FAIL cd_stat: got %0d expected 1", game_stat); end
        checks++; if (countdown !== 2'd3) begin errors++; $display("FAIL cd_start: got %0d expected 3", countdown); end
        nt = int'(frame_tick); n = 0;
        while (game_stat == 3'd1 && n < 200) begin
            step(); n++;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL cd_vec: got %h expected %h", dut_vec, exp_vec());
            end
            if (game_stat == 3'd1 && frame_tick) nt++;
        end
        checks++; if (nt != CS * CF) begin errors++; $display("FAIL cd_length: got %0d ticks expected %0d", nt, CS * CF); end
        checks++; if (game_stat !== 3'd2 || countdown !== 2'd0) begin
            errors++; $display("FAIL cd_race: got stat %0d cd %0d expected 2 0", game_stat, countdown);
        end
        n_ft = 0; n_up = 0;
        repeat (24) begin
            step();
            n_ft += int'(frame_tick); n_up += int'(update_en);
            checks++;
            if (update_en !== frame_tick) begin
                errors++; $display("FAIL race_update_en: got %b expected %b", update_en, frame_tick);
            end
        end
        checks++; if (n_up != 3) begin errors++; $display("FAIL race_update_count: got %0d expected 3", n_up); end
    endtask

    task automatic test_laps();
        logic [1:0] ids [5];
        ids = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 5; i++) begin
            cp_id = ids[i]; cp_hit = 1; step(); cp_hit = 0;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL lap_vec_%0d: got %h expected %h", i, dut_vec, exp_vec());
            end
            if (i < 4) begin
                checks++;
                if (lap !== 2'd0 || game_stat !== 3'd2) begin
                    errors++; $display("FAIL lap_early_%0d: got lap %0d stat %0d expected 0 2", i, lap, game_stat);
                end
                repeat ($urandom_range(0, 3)) step();
            end
        end
        checks++; if (lap !== 2'd1 || game_stat !== 3'd3) begin
            errors++; $display("FAIL lap_win: got lap %0d stat %0d expected 1 3", lap, game_stat);
        end
    endtask

    task automatic test_opp_win();
        logic [1:0] ids [3];
        go_race();
        r_opp_game = 3'd3; step(); r_opp_game = 3'd0;
        checks++; if (game_stat !== 3'd4) begin errors++; $display("FAIL opp_lose: got %0d expected 4", game_stat); end
        go_race();
        ids = '{2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 3; i++) begin
            cp_id = ids[i]; cp_hit = 1; step(); cp_hit = 0;
        end
        cp_id = 2'd0; cp_hit = 1; r_opp_game = 3'd3; step(); cp_hit = 0; r_opp_game = 3'd0;
        checks++; if (game_stat !== 3'd3 || lap !== 2'd1) begin
            errors++; $display("FAIL tie_win: got stat %0d lap %0d expected 3 1", game_stat, lap);
        end
    endtask

    task automatic test_remote();
        btnu = 1; step(); btnu = 0; step();
        checks++; if (game_stat !== 3'd0 || lap !== 2'd0) begin
            errors++; $display("FAIL restart_idle: got stat %0d lap %0d expected 0 0", game_stat, lap);
        end
        r_opp_game = 3'd1; step(); r_opp_game = 3'd0;
        checks++; if (game_stat !== 3'd1 || player_rst !== 1'b1) begin
            errors++; $display("FAIL remote_start: got stat %0d prst %b expected 1 1", game_stat, player_rst);
        end
        go_race();
        cp_id = 2'd1; cp_hit = 1; step(); cp_hit = 0;
        r_opp_rst = 1; step(); r_opp_rst = 0;
        checks++; if (game_stat !== 3'd0 || lap !== 2'd0 || player_rst !== 1'b1 || countdown !== 2'd0) begin
            errors++; $display("FAIL remote_rst: got stat %0d lap %0d prst %b cd %0d expected 0 0 1 0",
                               game_stat, lap, player_rst, countdown);
        end
        step();
        checks++; if (player_rst !== 1'b0 || game_stat !== 3'd0) begin
            errors++; $display("FAIL remote_rst_pulse: got prst %b stat %0d expected 0 0", player_rst, game_stat);
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) btnu = ~btnu;
            cp_hit = ($urandom_range(0, 2) == 0);
            cp_id = 2'($urandom_range(0, 3));
            r_opp_game = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 4)) : 3'd0;
            r_opp_rst = ($urandom_range(0, 199) == 0);
            step();
            if (dut_vec !== exp_vec()) begin
                bad++;
                if (bad < 5) $display("FAIL random_vec cycle %0d: got %h expected %h", i, dut_vec, exp_vec());
            end
        end
        cp_hit = 0; r_opp_game = 0; r_opp_rst = 0; btnu = 0;
        checks++; if (bad != 0) begin errors++; $display("FAIL random_total: %0d cycles differ, required 0", bad); end
    endtask

    task automatic test_async_reset();
        r_opp_rst = 1; step(); r_opp_rst = 0; step();
        btnu = 1; step(); btnu = 0; step(); step();
        checks++; if (game_stat !== 3'd1) begin errors++; $display("FAIL ar_setup: got %0d expected 1", game_stat); end
        #2 rst = 0; model_reset();
        #1;
        checks++; if (dut_vec !== 10'd0) begin errors++; $display("FAIL ar_clear: got %h expected 0", dut_vec); end
        @(negedge clk);
        step();
        rst = 1;
        step();
        btnu = 1; step(); btnu = 0;
        checks++; if (game_stat !== 3'd1 || countdown !== 2'd3 || player_rst !== 1'b1) begin
            errors++; $display("FAIL ar_resume: got stat %0d cd %0d prst %b expected 1 3 1", game_stat, countdown, player_rst);
        end
        checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL ar_vec: got %h expected %h", dut_vec, exp_vec()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_countdown();
        test_laps();
        test_opp_win();
        test_remote();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
